// File: rtl/multi_voice_tone_gen_if.sv
// Register-write and sample-output bundle for multi_voice_tone_gen.
// The front end drives the master side and the tone generator sits on the slave side.
interface multi_voice_tone_gen_if #(
  parameter int NUM_CH = 4,
  parameter int FREQ_W = 16,
  parameter int OUT_W  = 8
) ();
  localparam int CH_W = $clog2(NUM_CH);

  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [1:0]        wr_reg;
  logic [FREQ_W-1:0] wr_data;
  logic [OUT_W-1:0]  sample_out;
  logic              sample_valid;

  modport master (
    output wr_en, wr_ch, wr_reg, wr_data,
    input  sample_out, sample_valid
  );

  modport slave (
    input  wr_en, wr_ch, wr_reg, wr_data,
    output sample_out, sample_valid
  );
endinterface

// File: rtl/multi_voice_tone_gen.sv
// Time-multiplexed phase-accumulator tone generator: one voice per clk, one averaged sample per frame.
// Define TONEGEN_NOISE_EN to add a per-voice 16-bit Galois LFSR noise source selected by ctrl bit 6.
module multi_voice_tone_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 24,
  parameter int FREQ_W = 16,
  parameter int OUT_W  = 8,
  parameter int VOL_W  = 4
) (
  input logic                  clk,
  input logic                  reset,
  multi_voice_tone_gen_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SUM_W = OUT_W + CH_W;
  localparam int SHIFT = ACC_W - FREQ_W;

  logic [ACC_W-1:0]  acc_r  [NUM_CH];
  logic [FREQ_W-1:0] freq_r [NUM_CH];
  logic [1:0]        mode_r [NUM_CH];
  logic [VOL_W-1:0]  vol_r  [NUM_CH];
  logic [CH_W-1:0]   slot_r;
  logic [SUM_W-1:0]  sum_r;
  logic              frame_done_r;
  logic [OUT_W-1:0]  sample_r;
  logic              valid_r;

  logic [ACC_W-1:0]  inc_s;
  logic [ACC_W-1:0]  acc_sum_s;
  logic [OUT_W-1:0]  phase_s;
  logic [OUT_W-1:0]  wave_s;
  logic [OUT_W-1:0]  scaled_s;

`ifdef TONEGEN_NOISE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_r  [NUM_CH];
  logic        noise_r [NUM_CH];
  logic        carry_s;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction
`endif

  function automatic logic [OUT_W-1:0] shape(input logic [1:0] mode, input logic [OUT_W-1:0] p);
    logic [OUT_W-1:0] tri_v;
    tri_v = {p[OUT_W-2:0], 1'b0};
    case (mode)
      2'd1:    shape = p[OUT_W-1] ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
      2'd2:    shape = p;
      2'd3:    shape = p[OUT_W-1] ? ~tri_v : tri_v;
      default: shape = {OUT_W{1'b0}};
    endcase
  endfunction

  // Waveform and volume scaling for the voice in the current slot.
  always_comb begin
    inc_s   = ACC_W'(freq_r[slot_r]) << SHIFT;
`ifdef TONEGEN_NOISE_EN
    {carry_s, acc_sum_s} = {1'b0, acc_r[slot_r]} + {1'b0, inc_s};
`else
    acc_sum_s = acc_r[slot_r] + inc_s;
`endif
    phase_s = acc_r[slot_r][ACC_W-1 -: OUT_W];
`ifdef TONEGEN_NOISE_EN
    if (noise_r[slot_r]) begin
      wave_s = lfsr_r[slot_r][OUT_W-1:0];
    end else begin
      wave_s = shape(mode_r[slot_r], phase_s);
    end
`else
    wave_s = shape(mode_r[slot_r], phase_s);
`endif
    scaled_s = OUT_W'(({{VOL_W{1'b0}}, wave_s} * {{OUT_W{1'b0}}, vol_r[slot_r]}) >> VOL_W);
  end

  // Per-voice state; a phase-reset write is placed last so it overrides the accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_r[i]  <= '0;
        freq_r[i] <= '0;
        mode_r[i] <= 2'd0;
        vol_r[i]  <= '0;
`ifdef TONEGEN_NOISE_EN
        lfsr_r[i]  <= LFSR_SEED;
        noise_r[i] <= 1'b0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (slot_r == CH_W'(i)) begin
          acc_r[i] <= acc_sum_s;
`ifdef TONEGEN_NOISE_EN
          if (carry_s) begin
            lfsr_r[i] <= lfsr_step(lfsr_r[i]);
          end
`endif
        end
        if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
          case (bus.wr_reg)
            2'd0: freq_r[i] <= bus.wr_data;
            2'd1: begin
              mode_r[i] <= bus.wr_data[5:4];
              vol_r[i]  <= bus.wr_data[VOL_W-1:0];
`ifdef TONEGEN_NOISE_EN
              noise_r[i] <= bus.wr_data[6];
`endif
            end
            2'd2: begin
              acc_r[i] <= '0;
`ifdef TONEGEN_NOISE_EN
              lfsr_r[i] <= LFSR_SEED;
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Slot sequencing, frame mixing and the registered sample output.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_r       <= '0;
      sum_r        <= '0;
      frame_done_r <= 1'b0;
      sample_r     <= '0;
      valid_r      <= 1'b0;
    end else begin
      slot_r       <= slot_r + CH_W'(1);
      sum_r        <= (slot_r == '0) ? SUM_W'(scaled_s) : sum_r + SUM_W'(scaled_s);
      frame_done_r <= (slot_r == CH_W'(NUM_CH - 1));
      valid_r      <= frame_done_r;
      if (frame_done_r) begin
        sample_r <= OUT_W'(sum_r >> CH_W);
      end
    end
  end

  assign bus.sample_out   = sample_r;
  assign bus.sample_valid = valid_r;
endmodule

// File: tb/tb_multi_voice_tone_gen.sv
// Directed, self-checking bench for multi_voice_tone_gen (4 voices, default widths).
// Expected samples are hand-computed; the noise vector switches expectations on TONEGEN_NOISE_EN.
module tb_multi_voice_tone_gen;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  always #5 clk = ~clk;

  multi_voice_tone_gen_if #(.NUM_CH(4), .FREQ_W(16), .OUT_W(8)) bus ();

  multi_voice_tone_gen #(
    .NUM_CH(4), .ACC_W(24), .FREQ_W(16), .OUT_W(8), .VOL_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string           name;
    int              nw;
    logic [7:0][19:0] w;      // {ch[1:0], reg[1:0], data[15:0]}
    logic [5:0][7:0]  exp_s;  // exp_s[0] is the first sample after the writes
  } vec_t;

  vec_t vecs[6];

  function automatic logic [5:0][7:0] seq6(input logic [7:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] rg, input logic [15:0] dat);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = ch;
    bus.wr_reg  = rg;
    bus.wr_data = dat;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start();
    reset      = 1'b1;
    bus.wr_en  = 1'b0;
    repeat (2) tick();
    reset      = 1'b0;
  endtask

  task automatic expect_sample(input string name, input logic [7:0] exp);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (bus.sample_valid) got = 1'b1;
    end
    if (got) begin
      check(name, bus.sample_out, exp);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no sample_valid within 12 clk, expected %h", name, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_ch   = 2'd0;
    bus.wr_reg  = 2'd0;
    bus.wr_data = 16'h0000;

    vecs[0].name = "sq_ch0";  vecs[0].nw = 2;
    vecs[0].w[0] = {2'd0, 2'd0, 16'h8000};
    vecs[0].w[1] = {2'd0, 2'd1, 16'h001F};
    vecs[0].exp_s = seq6(8'h00, 8'h00, 8'h3B, 8'h00, 8'h3B, 8'h00);

    vecs[1].name = "sq_all";  vecs[1].nw = 8;
    for (int c = 0; c < 4; c++) begin
      vecs[1].w[c]     = {2'(c), 2'd0, 16'h8000};
      vecs[1].w[c + 4] = {2'(c), 2'd1, 16'h001F};
    end
    vecs[1].exp_s = seq6(8'h00, 8'hEF, 8'h00, 8'hEF, 8'h00, 8'hEF);

    vecs[2].name = "tri_ch0"; vecs[2].nw = 2;
    vecs[2].w[0] = {2'd0, 2'd0, 16'h4000};
    vecs[2].w[1] = {2'd0, 2'd1, 16'h003F};
    vecs[2].exp_s = seq6(8'h00, 8'h00, 8'h1E, 8'h3B, 8'h1D, 8'h00);

    vecs[3].name = "vol8_reg3"; vecs[3].nw = 3;
    vecs[3].w[0] = {2'd0, 2'd0, 16'h8000};
    vecs[3].w[1] = {2'd0, 2'd1, 16'h0018};
    vecs[3].w[2] = {2'd0, 2'd3, 16'hFFFF};
    vecs[3].exp_s = seq6(8'h00, 8'h00, 8'h1F, 8'h00, 8'h1F, 8'h00);

    vecs[4].name = "vol0";    vecs[4].nw = 2;
    vecs[4].w[0] = {2'd1, 2'd0, 16'h8000};
    vecs[4].w[1] = {2'd1, 2'd1, 16'h0010};
    vecs[4].exp_s = seq6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    vecs[5].name = "noise_ch3"; vecs[5].nw = 2;
    vecs[5].w[0] = {2'd3, 2'd1, 16'h004F};
    vecs[5].w[1] = {2'd3, 2'd0, 16'hFFFF};
`ifdef TONEGEN_NOISE_EN
    // LFSR low bytes E1, E1, 70, 38, 9C, 4E, each scaled by 15/16 and divided by 4.
    vecs[5].exp_s = seq6(8'h34, 8'h34, 8'h1A, 8'h0D, 8'h24, 8'h12);
`else
    vecs[5].exp_s = seq6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

    // Reset held 3 clk while a voice is running and a write is pending.
    start();
    wr(2'd0, 2'd0, 16'h8000);
    wr(2'd0, 2'd1, 16'h001F);
    expect_sample("pre_f0", 8'h00);
    expect_sample("pre_f1", 8'h00);
    expect_sample("pre_f2", 8'h3B);
    reset       = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'd0;
    bus.wr_reg  = 2'd1;
    bus.wr_data = 16'h003F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out", bus.sample_out, 8'h00);
      check("rst_valid", {7'd0, bus.sample_valid}, 8'h00);
    end
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (bus.sample_valid) lat = i;
    end
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL rst_latency: got %0d clk, expected 5", lat);
    end
    check("rst_first", bus.sample_out, 8'h00);
    tick();
    check("valid_pulse", {7'd0, bus.sample_valid}, 8'h00);
    expect_sample("rst_f1", 8'h00);
    expect_sample("rst_f2", 8'h00);

    // Table-driven vectors, each from a fresh reset.
    for (int v = 0; v < 6; v++) begin
      start();
      for (int k = 0; k < vecs[v].nw; k++) begin
        wr(vecs[v].w[k][19:18], vecs[v].w[k][17:16], vecs[v].w[k][15:0]);
      end
      for (int j = 0; j < 6; j++) begin
        expect_sample($sformatf("%s[%0d]", vecs[v].name, j), vecs[v].exp_s[j]);
      end
    end

    // Saw on ch1: phase byte equals the frame number, wrapping after 256 frames.
    start();
    wr(2'd1, 2'd0, 16'h0100);
    wr(2'd1, 2'd1, 16'h002F);
    expect_sample("saw_f0", 8'h00);
    for (int k = 1; k <= 300; k++) begin
      int p;
      p = k % 256;
      expect_sample($sformatf("saw_f%0d", k), 8'(((p * 15) >> 4) >> 2));
    end

    // Four aligned squares, then a phase reset of ch2 while its phase is high.
    start();
    for (int c = 0; c < 4; c++) wr(2'(c), 2'd0, 16'h8000);
    for (int c = 0; c < 4; c++) wr(2'(c), 2'd1, 16'h001F);
    expect_sample("prst_f1", 8'h00);
    wr(2'd2, 2'd2, 16'h0000);
    expect_sample("prst_f2", 8'hB3);
    expect_sample("prst_f3", 8'h3B);
    expect_sample("prst_f4", 8'hB3);
    expect_sample("prst_f5", 8'h3B);

    // Frequency write landing on the clk that services ch0.
    start();
    wr(2'd0, 2'd1, 16'h001F);
    expect_sample("same_f0", 8'h00);
    repeat (3) tick();
    wr(2'd0, 2'd0, 16'h8000);
    expect_sample("same_f2", 8'h00);
    expect_sample("same_f3", 8'h00);
    expect_sample("same_f4", 8'h3B);
    expect_sample("same_f5", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
